// File: rtl/ray_dispatch_pkg.sv
// Shared types and constants for the ray dispatcher.
// The per-unit statistics counters are enabled with RAY_DISPATCH_STATS_EN.
package ray_dispatch_pkg;

    localparam int MAX_UNITS   = 16;
    localparam int COUNT_WIDTH = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } disp_state_e;

    // A single unit still needs a one-bit pointer register.
    function automatic int ptr_width(input int units);
        return (units > 1) ? $clog2(units) : 1;
    endfunction

endpackage

// File: rtl/round_robin_picker.sv
// Round-robin picker: grants the first requester at or after the pointer,
// wrapping from the top index back to 0.
module round_robin_picker #(
    parameter int UNITS = 4,
    parameter int PTR_W = 2
) (
    input  logic [UNITS-1:0] request_i,
    input  logic [PTR_W-1:0] pointer_i,
    output logic [UNITS-1:0] grant_o,
    output logic [PTR_W-1:0] index_o,
    output logic             valid_o
);

    logic [UNITS-1:0] upper_req;
    logic [UNITS-1:0] pick_vec;

    // Requests at or above the pointer win; otherwise wrap to the lowest.
    for (genvar gi = 0; gi < UNITS; gi++) begin : g_upper
        assign upper_req[gi] = request_i[gi] && (gi >= int'(pointer_i));
    end

    assign pick_vec = (|upper_req) ? upper_req : request_i;
    assign valid_o  = |request_i;

    always_comb begin
        index_o = '0;
        for (int i = UNITS - 1; i >= 0; i--) begin
            if (pick_vec[i]) begin
                index_o = PTR_W'(i);
            end
        end
    end

    always_comb begin
        grant_o = '0;
        for (int i = 0; i < UNITS; i++) begin
            grant_o[i] = valid_o && (index_o == PTR_W'(i));
        end
    end

endmodule

// File: rtl/ray_dispatcher.sv
// One-entry ray buffer that hands each ray to a ready unit in round-robin order.
// Define RAY_DISPATCH_STATS_EN to add saturating per-unit dispatch counters (unitCount).
module ray_dispatcher
    import ray_dispatch_pkg::*;
#(
    parameter int UNITS          = 4,
    parameter int POSITION_WIDTH = 16,
    parameter int ADDRESS_WIDTH  = 32
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                flush,
    input  logic                                inStart,
    output logic                                inReady,
    input  logic [2:0][POSITION_WIDTH-1:0]      inV,
    input  logic [ADDRESS_WIDTH-1:0]            inAddress,
    output logic [UNITS-1:0]                    unitStart,
    input  logic [UNITS-1:0]                    unitReady,
    input  logic [UNITS-1:0]                    unitBusy,
    output logic [2:0][POSITION_WIDTH-1:0]      outV,
    output logic [ADDRESS_WIDTH-1:0]            outAddress,
    output logic                                idle,
`ifdef RAY_DISPATCH_STATS_EN
    output logic [UNITS-1:0][COUNT_WIDTH-1:0]   unitCount,
`endif
    output logic [31:0]                         rayCount
);

    localparam int PTR_W = ptr_width(UNITS);

    disp_state_e                      state_q, state_d;
    logic [PTR_W-1:0]                 ptr_q, ptr_d;
    logic [2:0][POSITION_WIDTH-1:0]   v_q, v_d;
    logic [ADDRESS_WIDTH-1:0]         addr_q, addr_d;
    logic [31:0]                      ray_count_q, ray_count_d;

    logic [UNITS-1:0] pick_grant;
    logic [PTR_W-1:0] pick_index;
    logic             pick_valid;
    logic             dispatch;
    logic             accept;
    logic [PTR_W-1:0] ptr_after_pick;

    round_robin_picker #(
        .UNITS (UNITS),
        .PTR_W (PTR_W)
    ) u_picker (
        .request_i (unitReady),
        .pointer_i (ptr_q),
        .grant_o   (pick_grant),
        .index_o   (pick_index),
        .valid_o   (pick_valid)
    );

    // Flush blocks both sides so no ray is handed over or accepted and then lost.
    assign dispatch  = (state_q == ST_FULL) && pick_valid && !flush;
    assign inReady   = !flush && ((state_q == ST_EMPTY) || pick_valid);
    assign accept    = inStart && inReady;
    assign unitStart = dispatch ? pick_grant : '0;

    assign ptr_after_pick = (pick_index == PTR_W'(UNITS - 1)) ? '0 : pick_index + PTR_W'(1);

    assign outV       = v_q;
    assign outAddress = addr_q;
    assign rayCount   = ray_count_q;
    assign idle       = (state_q == ST_EMPTY) && (unitBusy == '0) && !inStart;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        v_d         = v_q;
        addr_d      = addr_q;
        ray_count_d = ray_count_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            ptr_d       = '0;
            ray_count_d = '0;
        end else begin
            if (dispatch) begin
                state_d     = ST_EMPTY;
                ptr_d       = ptr_after_pick;
                ray_count_d = ray_count_q + 32'd1;
            end
            // An accept in the dispatch cycle refills the register with no bubble.
            if (accept) begin
                state_d = ST_FULL;
                v_d     = inV;
                addr_d  = inAddress;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            ptr_q       <= '0;
            v_q         <= '0;
            addr_q      <= '0;
            ray_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            v_q         <= v_d;
            addr_q      <= addr_d;
            ray_count_q <= ray_count_d;
        end
    end

`ifdef RAY_DISPATCH_STATS_EN
    for (genvar gi = 0; gi < UNITS; gi++) begin : g_stats
        logic [COUNT_WIDTH-1:0] count_q;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                count_q <= '0;
            end else if (flush) begin
                count_q <= '0;
            end else if (unitStart[gi] && (count_q != '1)) begin
                count_q <= count_q + COUNT_WIDTH'(1);
            end
        end

        assign unitCount[gi] = count_q;
    end
`endif

endmodule

// File: tb/tb_ray_dispatcher.sv
// Self-checking bench for ray_dispatcher: directed scenarios plus randomized
// traffic compared against a queue-free behavioural model of the dispatcher.
module tb_ray_dispatcher;

    localparam int U  = 4;
    localparam int PW = 16;
    localparam int AW = 32;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  flush;
    logic                  inStart;
    logic                  inReady;
    logic [2:0][PW-1:0]    inV;
    logic [AW-1:0]         inAddress;
    logic [U-1:0]          unitStart;
    logic [U-1:0]          unitReady;
    logic [U-1:0]          unitBusy;
    logic [2:0][PW-1:0]    outV;
    logic [AW-1:0]         outAddress;
    logic                  idle;
    logic [31:0]           rayCount;
`ifdef RAY_DISPATCH_STATS_EN
    logic [U-1:0][15:0]    unitCount;
`endif

    always #5 clock = ~clock;

    ray_dispatcher #(
        .UNITS          (U),
        .POSITION_WIDTH (PW),
        .ADDRESS_WIDTH  (AW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .inStart    (inStart),
        .inReady    (inReady),
        .inV        (inV),
        .inAddress  (inAddress),
        .unitStart  (unitStart),
        .unitReady  (unitReady),
        .unitBusy   (unitBusy),
        .outV       (outV),
        .outAddress (outAddress),
        .idle       (idle),
`ifdef RAY_DISPATCH_STATS_EN
        .unitCount  (unitCount),
`endif
        .rayCount   (rayCount)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: is a ray held, what it is, where the search starts.
    bit                 m_full;
    logic [2:0][PW-1:0] m_v;
    logic [AW-1:0]      m_addr;
    int                 m_ptr;
    int unsigned        m_count;
    int                 m_ucount [U];

    int                 exp_grant;
    logic [U-1:0]       exp_start;
    bit                 exp_ready;
    bit                 exp_idle;

    function automatic int rr_pick(input logic [U-1:0] rdy, input int ptr);
        int u;
        for (int k = 0; k < U; k++) begin
            u = (ptr + k) % U;
            if (rdy[u]) return u;
        end
        return -1;
    endfunction

    function automatic logic [2:0][PW-1:0] rand_v();
        logic [2:0][PW-1:0] r;
        for (int i = 0; i < 3; i++) r[i] = PW'($urandom());
        return r;
    endfunction

    task automatic model_clear();
        m_full  = 1'b0;
        m_ptr   = 0;
        m_count = 0;
        for (int i = 0; i < U; i++) m_ucount[i] = 0;
    endtask

    // Drive one cycle of inputs on the falling edge and predict the outputs.
    task automatic apply(input bit st, input logic [2:0][PW-1:0] v, input logic [AW-1:0] a,
                         input logic [U-1:0] rdy, input logic [U-1:0] busy, input bit fl);
        @(negedge clock);
        inStart   = st;
        inV       = v;
        inAddress = a;
        unitReady = rdy;
        unitBusy  = busy;
        flush     = fl;
        #1;
        exp_grant = (m_full && !fl) ? rr_pick(rdy, m_ptr) : -1;
        exp_start = '0;
        if (exp_grant >= 0) exp_start[exp_grant] = 1'b1;
        exp_ready = !fl && (!m_full || exp_grant >= 0);
        exp_idle  = !m_full && (busy == '0) && !st;
    endtask

    task automatic advance();
        @(posedge clock);
        if (flush) begin
            model_clear();
        end else begin
            if (exp_grant >= 0) begin
                m_ptr = (exp_grant + 1) % U;
                m_count++;
                if (m_ucount[exp_grant] < 65535) m_ucount[exp_grant]++;
                m_full = 1'b0;
            end
            if (inStart && exp_ready) begin
                m_full = 1'b1;
                m_v    = inV;
                m_addr = inAddress;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; inStart = 1'b0; inV = '0; inAddress = '0;
        unitReady = '0; unitBusy = '0;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (unitStart !== '0) begin errors++; $display("FAIL reset_start got %b want 0", unitStart); end
        checks++;
        if (rayCount !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", rayCount); end
        reset = 1'b1;
        model_clear();
        m_v = '0; m_addr = '0;
        apply(1'b0, '0, '0, '0, '0, 1'b0);
        checks++;
        if (inReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", inReady); end
        checks++;
        if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle); end
        checks++;
        if (outV !== '0 || outAddress !== '0) begin
            errors++; $display("FAIL reset_data got %h/%h want 0/0", outV, outAddress);
        end
`ifdef RAY_DISPATCH_STATS_EN
        checks++;
        if (unitCount !== '0) begin errors++; $display("FAIL reset_unitcount got %h want 0", unitCount); end
`endif
        $display("reset: ready=%b idle=%b count=%0d", inReady, idle, rayCount);
        advance();
    endtask

    task automatic test_back_to_back();
        logic [U-1:0] want;
        logic [U-1:0] one;
        one = 1;
        for (int c = 0; c <= 8; c++) begin
            apply(c < 8, rand_v(), AW'(32'h1000 + c), '1, '0, 1'b0);
            want = (c == 0) ? '0 : (one << ((c - 1) % U));
            checks++;
            if (unitStart !== want) begin
                errors++; $display("FAIL b2b_order c=%0d got %b want %b", c, unitStart, want);
            end
            checks++;
            if (unitStart !== exp_start || inReady !== exp_ready) begin
                errors++; $display("FAIL b2b_model c=%0d got %b/%b want %b/%b", c, unitStart, inReady, exp_start, exp_ready);
            end
            if (exp_start != '0) begin
                checks++;
                if (outAddress !== m_addr || outV !== m_v) begin
                    errors++; $display("FAIL b2b_data c=%0d got %h want %h", c, outAddress, m_addr);
                end
            end
            $display("b2b c=%0d start=%b addr=%h", c, unitStart, outAddress);
            advance();
        end
        apply(1'b0, '0, '0, '1, '0, 1'b0);
        checks++;
        if (rayCount !== 32'd8) begin errors++; $display("FAIL b2b_count got %0d want 8", rayCount); end
        advance();
    endtask

    task automatic test_pointer();
        logic        st_tab   [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0]  rdy_tab  [7] = '{4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b1001, 4'b0011, 4'b1111};
        logic [3:0]  want_tab [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b1000, 4'b0001, 4'b0000};
        for (int s = 0; s < 7; s++) begin
            apply(st_tab[s], rand_v(), AW'($urandom()), rdy_tab[s], '0, 1'b0);
            checks++;
            if (unitStart !== want_tab[s] || unitStart !== exp_start) begin
                errors++; $display("FAIL pointer s=%0d got %b want %b", s, unitStart, want_tab[s]);
            end
            $display("pointer s=%0d ready=%b start=%b", s, rdy_tab[s], unitStart);
            advance();
        end
    endtask

    task automatic test_stall();
        logic [2:0][PW-1:0] hv;
        logic [AW-1:0]      ha;
        hv = rand_v();
        ha = AW'($urandom());
        apply(1'b1, hv, ha, '0, '0, 1'b0);
        advance();
        for (int c = 0; c < 5; c++) begin
            apply(1'b1, rand_v(), AW'($urandom()), '0, '0, 1'b0);
            checks++;
            if (inReady !== 1'b0 || unitStart !== '0) begin
                errors++; $display("FAIL stall_hold c=%0d got ready=%b start=%b want 0/0", c, inReady, unitStart);
            end
            checks++;
            if (outV !== hv || outAddress !== ha) begin
                errors++; $display("FAIL stall_data c=%0d got %h want %h", c, outAddress, ha);
            end
            $display("stall c=%0d ready=%b start=%b", c, inReady, unitStart);
            advance();
        end
        apply(1'b0, '0, '0, 4'b0010, '0, 1'b0);
        checks++;
        if (unitStart !== 4'b0010) begin errors++; $display("FAIL stall_release got %b want 0010", unitStart); end
        advance();
        apply(1'b0, '0, '0, '1, '0, 1'b0);
        checks++;
        if (unitStart !== '0) begin errors++; $display("FAIL stall_single got %b want 0000", unitStart); end
        $display("stall released to unit 1");
        advance();
    endtask

    task automatic test_accept_dispatch();
        apply(1'b1, rand_v(), 32'h0FC, '0, '0, 1'b0);
        advance();
        apply(1'b1, rand_v(), 32'h100, '1, '0, 1'b0);
        checks++;
        if (inReady !== 1'b1 || unitStart === '0 || unitStart !== exp_start) begin
            errors++; $display("FAIL overlap_first got ready=%b start=%b want 1/%b", inReady, unitStart, exp_start);
        end
        checks++;
        if (outAddress !== 32'h0FC) begin errors++; $display("FAIL overlap_addr0 got %h want 0fc", outAddress); end
        advance();
        apply(1'b0, '0, '0, '1, '0, 1'b0);
        checks++;
        if (outAddress !== 32'h100 || unitStart === '0 || unitStart !== exp_start) begin
            errors++; $display("FAIL overlap_second got %h/%b want 100/%b", outAddress, unitStart, exp_start);
        end
        $display("overlap: second ray addr=%h start=%b", outAddress, unitStart);
        advance();
    endtask

    task automatic test_flush();
        apply(1'b0, '0, '0, '0, '0, 1'b1);
        advance();
        for (int c = 0; c <= 5; c++) begin
            apply(1'b1, rand_v(), AW'($urandom()), '1, '0, 1'b0);
            advance();
        end
        apply(1'b0, '0, '0, '1, '0, 1'b1);
        checks++;
        if (rayCount !== 32'd5) begin errors++; $display("FAIL flush_precount got %0d want 5", rayCount); end
        checks++;
        if (unitStart !== '0 || inReady !== 1'b0) begin
            errors++; $display("FAIL flush_block got start=%b ready=%b want 0/0", unitStart, inReady);
        end
        advance();
        apply(1'b0, '0, '0, '1, '0, 1'b0);
        checks++;
        if (rayCount !== 32'd0 || unitStart !== '0 || idle !== 1'b1) begin
            errors++; $display("FAIL flush_after got count=%0d start=%b idle=%b want 0/0/1", rayCount, unitStart, idle);
        end
        advance();
        apply(1'b1, rand_v(), AW'($urandom()), '1, '0, 1'b0);
        advance();
        apply(1'b0, '0, '0, '1, '0, 1'b0);
        checks++;
        if (unitStart !== 4'b0001) begin errors++; $display("FAIL flush_unit0 got %b want 0001", unitStart); end
        $display("flush: next ray start=%b", unitStart);
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            apply(($urandom() % 4) != 0, rand_v(), AW'($urandom()), U'($urandom()),
                  (($urandom() % 3) == 0) ? U'($urandom()) : '0, ($urandom() % 25) == 0);
            checks++;
            if (unitStart !== exp_start || inReady !== exp_ready || idle !== exp_idle) begin
                errors++;
                $display("FAIL rand_ctrl c=%0d got %b/%b/%b want %b/%b/%b", c, unitStart, inReady, idle, exp_start, exp_ready, exp_idle);
            end
            checks++;
            if (rayCount !== m_count) begin errors++; $display("FAIL rand_count c=%0d got %0d want %0d", c, rayCount, m_count); end
            if (exp_start != '0) begin
                checks++;
                if (outV !== m_v || outAddress !== m_addr) begin
                    errors++; $display("FAIL rand_data c=%0d got %h want %h", c, outAddress, m_addr);
                end
            end
`ifdef RAY_DISPATCH_STATS_EN
            for (int i = 0; i < U; i++) begin
                checks++;
                if (unitCount[i] !== 16'(m_ucount[i])) begin
                    errors++; $display("FAIL rand_unitcount c=%0d u=%0d got %0d want %0d", c, i, unitCount[i], m_ucount[i]);
                end
            end
`endif
            $display("rand c=%0d start=%b ready=%b count=%0d", c, unitStart, inReady, rayCount);
            advance();
        end
    endtask

    task automatic test_reset_mid();
        apply(1'b1, rand_v(), AW'($urandom()), '0, '0, 1'b0);
        advance();
        apply(1'b1, rand_v(), AW'($urandom()), '0, '1, 1'b0);
        reset = 1'b0;
        #1;
        checks++;
        if (unitStart !== '0 || rayCount !== 32'd0) begin
            errors++; $display("FAIL midreset_clear got start=%b count=%0d want 0/0", unitStart, rayCount);
        end
`ifdef RAY_DISPATCH_STATS_EN
        checks++;
        if (unitCount !== '0) begin errors++; $display("FAIL midreset_unitcount got %h want 0", unitCount); end
`endif
        @(negedge clock);
        unitReady = '1; inStart = 1'b0; unitBusy = '0;
        #1;
        checks++;
        if (unitStart !== '0 || idle !== 1'b1) begin
            errors++; $display("FAIL midreset_hold got start=%b idle=%b want 0/1", unitStart, idle);
        end
        reset = 1'b1;
        model_clear();
        m_v = '0; m_addr = '0;
        apply(1'b0, '0, '0, '1, '0, 1'b0);
        checks++;
        if (unitStart !== '0 || idle !== 1'b1 || inReady !== 1'b1 || outAddress !== '0) begin
            errors++; $display("FAIL midreset_release got start=%b idle=%b ready=%b addr=%h want 0/1/1/0", unitStart, idle, inReady, outAddress);
        end
        $display("midreset: idle=%b ready=%b", idle, inReady);
        advance();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_pointer();
        test_stall();
        test_accept_dispatch();
        test_flush();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ray_dispatcher.md
RAY_DISPATCHER -- requirements
Module: ray_dispatcher

Interface
REQ-001 Parameter UNITS, 4, number of downstream ray units (1..16) SHALL be supported.
REQ-002 Parameter POSITION_WIDTH, 16, width of each ray direction component.
REQ-003 Parameter ADDRESS_WIDTH, 32, width of pixel address.
REQ-004 Port clock  input  1  single clock; all state SHALL be clocked on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clock).
REQ-006 Port flush  input  1  synchronous: discard held ray, return pointer to unit 0.
REQ-007 Port inStart  input  1  upstream ray valid; transfer when inStart && inReady.
REQ-008 Port inReady  output  1  dispatcher can accept a ray this cycle.
REQ-009 Port inV  input  3x POSITION_WIDTH signed  ray direction.
REQ-010 Port inAddress  input  ADDRESS_WIDTH  pixel address.
REQ-011 Port unitStart  output  UNITS  one-hot single-cycle start pulse to the chosen unit.
REQ-012 Port unitReady  input  UNITS  unit i can accept a ray this cycle.
REQ-013 Port unitBusy  input  UNITS  unit i is processing a ray.
REQ-014 Port outV / outAddress  output  as inV / inAddress  ray data shared by all units, valid while any unitStart bit is high.
REQ-015 Port idle  output  1  no held ray, no unit busy, no inStart.
REQ-016 Port rayCount  output  32  rays dispatched since reset/flush.

Function
REQ-017 State SHALL be EMPTY (no ray held) or FULL (one ray held in register).
REQ-018 EMPTY: inReady=1; on transfer latch inV/inAddress, go FULL; no bypass, so dispatch latency is exactly 1 cycle minimum.
REQ-019 FULL with no unitReady bit set: hold data, unitStart=0, inReady=0.
REQ-020 FULL with any unitReady bit: assert unitStart for the first ready unit at or after pointer (round-robin, wrap UNITS-1 -> 0), set pointer to chosen+1 mod UNITS.
REQ-021 Dispatch and accept SHALL occur in the same cycle: inReady=1 when FULL and dispatching; new ray replaces held ray, state stays FULL.
REQ-022 Dispatch without accept SHALL go to EMPTY.
REQ-023 unitStart SHALL be one-hot or zero, never multi-bit, and SHALL never target a unit with unitReady=0.
REQ-024 rayCount SHALL increment by 1 per dispatch, wrapping at 2^32.
REQ-025 flush SHALL take priority over accept and dispatch: state EMPTY, pointer 0, rayCount 0, unitStart 0 that cycle.
REQ-026 idle SHALL be combinational: EMPTY && unitBusy==0 && !inStart.
REQ-027 UNITS=1: pointer SHALL remain 0; behaviour otherwise identical.

Reset
REQ-028 On reset low: state EMPTY, pointer 0, rayCount 0, held data 0, unitStart 0, inReady 1 after release, per-unit counters 0.
REQ-029 Reset mid-operation SHALL drop the held ray without any unitStart pulse.

Configuration
REQ-030 Macro RAY_DISPATCH_STATS_EN defined: output unitCount (UNITS x 16) SHALL count dispatches per unit, saturating at 16'hFFFF, cleared by reset and flush.
REQ-031 Macro undefined: unitCount port and counters SHALL not exist; all other behaviour unchanged.

Structure
REQ-032 Package ray_dispatch_pkg SHALL hold the state enum type, MAX_UNITS=16 and COUNT_WIDTH=16 constants.
REQ-033 Round-robin selection SHALL be a sub-module round_robin_picker (inputs request vector, pointer; outputs one-hot grant, grant index, valid).

Verification
REQ-034 UNITS=4, all ready, 8 back-to-back rays -> unitStart sequence 0,1,2,3,0,1,2,3, first pulse 1 cycle after first accept, rayCount=8.
REQ-035 Pointer=2, unitReady=4'b1001 -> grant unit 3, pointer becomes 0; next with 4'b0011 -> grant unit 0.
REQ-036 FULL, unitReady=0 for 5 cycles -> inReady=0, outV/outAddress stable, no unitStart; unitReady[1]=1 -> single pulse on unit 1.
REQ-037 inStart with address 0x100 while FULL and dispatching 0x0FC -> 0x0FC dispatched, 0x100 held, no cycle bubble.
REQ-038 flush while FULL with rayCount=5 -> next cycle EMPTY, rayCount=0, no unitStart; next ray goes to unit 0.
REQ-039 reset low mid-stream with RAY_DISPATCH_STATS_EN -> all unitCount=0, idle=1 once inStart=0 and unitBusy=0.
